// File: rtl/playbus_pkg.sv
// Shared types and constants for the play-bus trainer: function codes,
// controller states and the fixed EPROM image.
package playbus_pkg;

    typedef enum logic [2:0] {
        SW_TO_RAM  = 3'd0,
        SW_TO_BUS  = 3'd1,
        SW_TO_LED  = 3'd2,
        RAM_TO_BUS = 3'd3,
        ROM_TO_LED = 3'd4,
        ROM_TO_RAM = 3'd5,
        RAM_TO_LED = 3'd6,
        NOP        = 3'd7
    } func_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    // Word a holds 8 + a, so addresses 0..7 read back 8..F.
    localparam logic [7:0][3:0] EPROM_CONTENTS = {
        4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8
    };

endpackage

// File: rtl/full_playbus1_hex_to_7seg.sv
// Hex digit to active-low seven-segment pattern (bit0 = a .. bit6 = g).
module hex_to_7seg (
    input  logic [3:0] hex_in,
    output logic [6:0] seg_out
);

    always_comb begin
        seg_out = 7'h7F;
        case (hex_in)
            4'h0: seg_out = 7'h40;
            4'h1: seg_out = 7'h79;
            4'h2: seg_out = 7'h24;
            4'h3: seg_out = 7'h30;
            4'h4: seg_out = 7'h19;
            4'h5: seg_out = 7'h12;
            4'h6: seg_out = 7'h02;
            4'h7: seg_out = 7'h78;
            4'h8: seg_out = 7'h00;
            4'h9: seg_out = 7'h10;
            4'hA: seg_out = 7'h08;
            4'hB: seg_out = 7'h03;
            4'hC: seg_out = 7'h46;
            4'hD: seg_out = 7'h21;
            4'hE: seg_out = 7'h06;
            4'hF: seg_out = 7'h0E;
        endcase
    end

endmodule

// File: rtl/full_playbus1.sv
// Play-bus trainer: switches drive a small RAM/EPROM/bus/LED datapath under a
// two-state controller; four seven-segment displays show bus, LED, address, op.
module full_playbus1
    import playbus_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw0,
    input  logic [ADDR_W-1:0] sw1,
    input  logic [2:0]        sw2,
    output logic [6:0]        disp0,
    output logic [6:0]        disp1,
    output logic [6:0]        disp2,
    output logic [6:0]        disp3
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    func_e             op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [DATA_W-1:0] ram_d [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= NOP;
            addr_q  <= '0;
            rd_q    <= '0;
            bus_q   <= '0;
            led_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            bus_q   <= bus_d;
            led_q   <= led_d;
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= ram_d[i];
            end
        end
    end

    // The memory read is captured into rd_q on the sampling edge, so the
    // transfer edge only moves a registered value and never reads RAM itself.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        bus_d   = bus_q;
        led_d   = led_q;
        ram_d   = ram_q;
        case (state_q)
            ST_IDLE: begin
                op_d   = func_e'(sw2);
                addr_d = sw1;
                case (func_e'(sw2))
                    SW_TO_RAM: begin
                        ram_d[sw1] = sw0;
                        bus_d      = sw0;
                    end
                    SW_TO_BUS: bus_d = sw0;
                    SW_TO_LED: begin
                        led_d = sw0;
                        bus_d = sw0;
                    end
                    RAM_TO_BUS, RAM_TO_LED: begin
                        rd_d    = ram_q[sw1];
                        state_d = ST_XFER;
                    end
                    ROM_TO_LED, ROM_TO_RAM: begin
                        rd_d    = DATA_W'(EPROM_CONTENTS[sw1]);
                        state_d = ST_XFER;
                    end
                    NOP: ;
                endcase
            end
            ST_XFER: begin
                state_d = ST_IDLE;
                case (op_q)
                    RAM_TO_BUS: bus_d = rd_q;
                    ROM_TO_LED, RAM_TO_LED: begin
                        bus_d = rd_q;
                        led_d = rd_q;
                    end
                    ROM_TO_RAM: begin
                        bus_d         = rd_q;
                        ram_d[addr_q] = rd_q;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [3:0] hex_in [4];
    logic [6:0] seg_out [4];

    assign hex_in[0] = 4'(bus_q);
    assign hex_in[1] = 4'(led_q);
    assign hex_in[2] = 4'(sw1);
    assign hex_in[3] = 4'(sw2);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_disp
            hex_to_7seg u_hex (
                .hex_in  (hex_in[gi]),
                .seg_out (seg_out[gi])
            );
        end
    endgenerate

    assign disp0 = seg_out[0];
    assign disp1 = seg_out[1];
    assign disp2 = seg_out[2];
    assign disp3 = seg_out[3];

endmodule

// File: tb/tb_full_playbus1.sv
// Table-driven check of full_playbus1: one vector per clock edge with
// hand-derived bus/LED results, queued as expectations and compared after the edge.
module tb_full_playbus1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw0;
    logic [2:0] sw1;
    logic [2:0] sw2;
    logic [6:0] disp0, disp1, disp2, disp3;

    int checks = 0;
    int errors = 0;

    full_playbus1 #(.DATA_W(4), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sw0   (sw0),
        .sw1   (sw1),
        .sw2   (sw2),
        .disp0 (disp0),
        .disp1 (disp1),
        .disp2 (disp2),
        .disp3 (disp3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] sw0;
        logic [2:0] sw1;
        logic [2:0] sw2;
        logic [3:0] bus;
        logic [3:0] led;
    } vec_t;

    typedef struct {
        int         idx;
        logic [6:0] d0;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [6:0] d3;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input int idx, input logic [6:0] act, input logic [6:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] s0, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [3:0] b, input logic [3:0] l);
        vec_t v;
        v.rst = r; v.sw0 = s0; v.sw1 = s1; v.sw2 = s2; v.bus = b; v.led = l;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // reset, sw0, sw1, sw2 -> bus, led after the edge
        add(1, 4'h0, 3'd0, 3'd7, 4'h0, 4'h0);
        add(0, 4'hA, 3'd0, 3'd0, 4'hA, 4'h0);  // RAM[0]=A
        add(0, 4'h5, 3'd0, 3'd1, 4'h5, 4'h0);
        add(0, 4'h5, 3'd0, 3'd3, 4'h5, 4'h0);  // read issued
        add(0, 4'h5, 3'd0, 3'd3, 4'hA, 4'h0);  // bus <= RAM[0]
        add(0, 4'h5, 3'd0, 3'd7, 4'hA, 4'h0);
        add(1, 4'h5, 3'd0, 3'd7, 4'h0, 4'h0);
        add(0, 4'h0, 3'd2, 3'd3, 4'h0, 4'h0);
        add(0, 4'h0, 3'd2, 3'd3, 4'h0, 4'h0);
        add(0, 4'hA, 3'd2, 3'd1, 4'hA, 4'h0);
        add(0, 4'hA, 3'd2, 3'd2, 4'hA, 4'hA);
        add(1, 4'h0, 3'd2, 3'd7, 4'h0, 4'h0);
        add(0, 4'h0, 3'd2, 3'd5, 4'h0, 4'h0);
        add(0, 4'h0, 3'd2, 3'd5, 4'hA, 4'h0);  // RAM[2] <= EPROM[2]
        add(0, 4'h0, 3'd2, 3'd1, 4'h0, 4'h0);
        add(0, 4'h0, 3'd2, 3'd6, 4'h0, 4'h0);
        add(0, 4'h0, 3'd2, 3'd6, 4'hA, 4'hA);
        add(0, 4'h0, 3'd7, 3'd4, 4'hA, 4'hA);
        add(0, 4'h0, 3'd7, 3'd4, 4'hF, 4'hF);
        add(0, 4'h3, 3'd7, 3'd7, 4'hF, 4'hF);
        add(0, 4'h3, 3'd7, 3'd7, 4'hF, 4'hF);
        add(0, 4'h0, 3'd1, 3'd3, 4'hF, 4'hF);
        add(0, 4'h9, 3'd4, 3'd0, 4'h0, 4'hF);  // switch changes during XFER ignored
        add(0, 4'h0, 3'd4, 3'd6, 4'h0, 4'hF);
        add(0, 4'h0, 3'd4, 3'd6, 4'h0, 4'h0);  // RAM[4] untouched
        add(0, 4'h0, 3'd3, 3'd5, 4'h0, 4'h0);
        add(1, 4'h0, 3'd3, 3'd5, 4'h0, 4'h0);  // reset aborts the transfer
        add(0, 4'h6, 3'd3, 3'd1, 4'h6, 4'h0);
        add(0, 4'h6, 3'd3, 3'd6, 4'h6, 4'h0);
        add(0, 4'h6, 3'd3, 3'd6, 4'h0, 4'h0);
        add(0, 4'h6, 3'd3, 3'd5, 4'h0, 4'h0);
        add(0, 4'h6, 3'd3, 3'd5, 4'hB, 4'h0);
        add(0, 4'h6, 3'd3, 3'd5, 4'hB, 4'h0);  // repeat is idempotent
        add(0, 4'h6, 3'd3, 3'd5, 4'hB, 4'h0);
        add(0, 4'h6, 3'd3, 3'd6, 4'hB, 4'h0);
        add(0, 4'h6, 3'd3, 3'd6, 4'hB, 4'hB);
        add(0, 4'h0, 3'd0, 3'd4, 4'hB, 4'hB);
        add(0, 4'h0, 3'd0, 3'd4, 4'h8, 4'h8);

        reset = 1'b1; sw0 = '0; sw1 = '0; sw2 = 3'd7;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            sw0   = vecs[i].sw0;
            sw1   = vecs[i].sw1;
            sw2   = vecs[i].sw2;
            e.idx = i;
            e.d0  = seg(vecs[i].bus);
            e.d1  = seg(vecs[i].led);
            e.d2  = seg({1'b0, vecs[i].sw1});
            e.d3  = seg({1'b0, vecs[i].sw2});
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", i);
            end else begin
                e = sb.pop_front();
                chk("disp0_bus", e.idx, disp0, e.d0);
                chk("disp1_led", e.idx, disp1, e.d1);
                chk("disp2_addr", e.idx, disp2, e.d2);
                chk("disp3_func", e.idx, disp3, e.d3);
                $display("vec %0d rst=%0d sw0=%h sw1=%0d sw2=%0d disp0=%h disp1=%h",
                         e.idx, reset, sw0, sw1, sw2, disp0, disp1);
            end
        end

        // Address/function displays are combinational: sweep between edges.
        @(negedge clk);
        sw2 = 3'd7;
        for (int a = 0; a < 8; a++) begin
            logic [2:0] av;
            av  = 3'(a);
            sw1 = av;
            sw2 = 3'(7 - a);
            #1;
            chk("disp2_comb", a, disp2, seg({1'b0, av}));
            chk("disp3_comb", a, disp3, seg({1'b0, 3'(7 - a)}));
            $display("comb %0d sw1=%0d sw2=%0d disp2=%h disp3=%h", a, sw1, sw2, disp2, disp3);
            sw2 = 3'd7;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_playbus1.md
FULL_PLAYBUS1 -- requirements
Module: full_playbus1

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high); sw0 input 4 (data switches); sw1 input 3 (address); sw2 input 3 (function code); disp0..disp3 output 7 each (seven-segment displays).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 Segment outputs SHALL be active-low (0 = lit), bit0=a .. bit6=g.
REQ-004 Parameter DATA_W, default 4, data width; parameter ADDR_W, default 3, address width (RAM/EPROM depth 2**ADDR_W = 8).

Function
REQ-005 Internal state SHALL be: 8x4 RAM, 8x4 constant EPROM, 4-bit bus register, 4-bit LED register, controller FSM {IDLE, XFER}.
REQ-006 EPROM contents SHALL be EPROM[a] = 8 + a (addresses 0..7 hold 8..F).
REQ-007 In IDLE, sw2 and sw1 SHALL be sampled on every rising edge; the sampled values are held internally until the operation completes.
REQ-008 Single-cycle ops (complete at the sampling edge, FSM stays IDLE): 0 = RAM[sw1]<=sw0, bus<=sw0; 1 = bus<=sw0; 2 = LED<=sw0, bus<=sw0; 7 = no-op, all registers hold.
REQ-009 Memory-source ops (3,4,5,6) SHALL take two edges: edge 1 in IDLE issues the read and goes to XFER; edge 2 in XFER performs the transfer and returns to IDLE.
REQ-010 The transfer edge SHALL do: 3 = bus<=RAM[addr]; 4 = bus<=EPROM[addr], LED<=EPROM[addr]; 5 = bus<=EPROM[addr], RAM[addr]<=EPROM[addr]; 6 = bus<=RAM[addr], LED<=RAM[addr].
REQ-011 During XFER, changes on sw0/sw1/sw2 SHALL be ignored.
REQ-012 An op SHALL re-execute on each new IDLE sampling edge while sw2 is held; repetition is idempotent.
REQ-013 Displays SHALL be combinational: disp0 = hex(bus), disp1 = hex(LED), disp2 = hex({0,sw1}), disp3 = hex({0,sw2}).
REQ-014 Hex decode SHALL cover 0-F: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
REQ-015 A RAM read in the same op as a RAM write SHALL return the pre-write value; no write and read of RAM occur together in any defined op.

Reset
REQ-016 While reset=1 at a rising edge: FSM<=IDLE, bus<=0, LED<=0, all RAM words<=0; disp0 and disp1 then show 0x40.
REQ-017 Reset during XFER SHALL abort the op with no destination write.
REQ-018 Reset SHALL take priority over any function code.

Structure
REQ-019 Package playbus_pkg SHALL hold the function-code enum (SW_TO_RAM=0, SW_TO_BUS=1, SW_TO_LED=2, RAM_TO_BUS=3, ROM_TO_LED=4, ROM_TO_RAM=5, RAM_TO_LED=6, NOP=7), the state enum, and the EPROM contents constant.
REQ-020 One sub-module hex_to_7seg (4-bit in, 7-bit out) SHALL be instantiated four times; RAM, EPROM, and controller stay in full_playbus1.

Verification
REQ-021 Reset, then 1 clk -> bus=0, LED=0; disp0=disp1=0x40; disp3 follows sw2.
REQ-022 sw0=A, sw1=0, sw2=0, 1 edge; then sw2=3, sw1=0, 2 edges -> bus=A, disp0=0x08.
REQ-023 sw1=2, sw2=3, 2 edges after reset -> bus=0; then sw2=1, sw0=A, 1 edge -> bus=A; then sw2=2, 1 edge -> LED=A, disp1=0x08.
REQ-024 sw1=2, sw2=5, 2 edges -> RAM[2]=A and bus=A; then sw2=6, 2 edges -> LED=A.
REQ-025 sw1=7, sw2=4, 2 edges -> bus=F, LED=F, disp1=0x0E; then sw2=7, 1 edge -> no change.
REQ-026 sw2=5 and 1 edge (XFER), then reset=1 for 1 edge -> RAM[sw1] stays 0, FSM=IDLE.
